clb_cfg_loader: RTL
===================

CLB_CFG_LOADER -- requirements
Module: clb_cfg_loader

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset, with ports named K and RST.
REQ-002 The block SHALL have port K, input, width 1: rising-edge clock.
REQ-003 The block SHALL have port RST, input, width 1: synchronous active-high reset.
REQ-004 The block SHALL have port DIN, input, width 1: serial bitstream data.
REQ-005 The block SHALL have port DVALID, input, width 1: DIN is consumed only on cycles where DVALID=1.
REQ-006 The block SHALL have port CFG, output, width 37: committed CLB configuration word, registered.
REQ-007 The block SHALL have port DONE, output, width 1: one-cycle pulse on frame commit.
REQ-008 The block SHALL have port ERR, output, width 1: last frame failed parity; level signal.
REQ-009 The block SHALL have port BUSY, output, width 1: high while in LOAD or PARITY.
REQ-010 The CFG field map SHALL be: [36:35] S-mux select, [34:33] clock-mux select, [32:31] R-mux select, [30:29] X-mux select, [28:27] Y-mux select, [26:11] 16-entry LUT, [10:9] combinational option, [8:6] F-side input-mux selects, [5:3] G-side input-mux selects, [2] DQ1 select, [1] DQ2 select, [0] flop/latch select.

Function
REQ-011 The FSM SHALL have states SYNC, LOAD, PARITY; a valid bit advances the FSM, and DVALID=0 holds all state, counters and shift registers.
REQ-012 In SYNC, the block SHALL shift each valid bit into an 8-bit window, and the FSM SHALL enter LOAD on the same edge the window equals 8'b1111_0010 (newest bit in LSB).
REQ-013 In LOAD, the block SHALL shift 37 valid bits MSB-first (first bit lands in CFG[36]) into a staging register, using a 6-bit counter 0..36; the 37th bit SHALL move the FSM to PARITY.
REQ-014 In PARITY, the block SHALL accept one valid bit P; even parity SHALL pass when XOR(staging[36:0], P) = 0.
REQ-015 On pass, CFG SHALL load the staging register and DONE SHALL assert on the next cycle, for exactly 1 cycle; ERR SHALL clear to 0 at the same time.
REQ-016 On fail, CFG SHALL remain unchanged, ERR SHALL be set to 1, and DONE SHALL remain 0.
REQ-017 ERR SHALL be held until the next passing frame or RST.
REQ-018 After PARITY (pass or fail), the FSM SHALL return to SYNC with the sync window cleared to 8'h00, so a new header is required.
REQ-019 Header bits arriving during LOAD SHALL be treated as data, with no resynchronisation mid-frame.
REQ-020 CFG SHALL never be partially updated; staging SHALL be invisible on CFG.
REQ-021 BUSY SHALL be registered and high exactly while the FSM is in LOAD or PARITY.
REQ-022 Latency from the accepted parity bit to the CFG update and DONE pulse SHALL be 1 K edge.

Reset
REQ-023 When RST=1 at a K edge, the block SHALL enter SYNC, clear the window, counter and staging register to 0, and set DONE=0, ERR=0, BUSY=0.
REQ-024 On RST, CFG SHALL be set to 37'h15_0008_B038 (S/clock/R mux = 2'b10, X/Y mux = 2'b00, LUT = 16'h0116, comb option = 00, F-side selects = 000, G-side selects = 111, DQ selects = 0, flop mode).
REQ-025 RST SHALL take priority over DVALID, and RST asserted mid-LOAD SHALL abort the frame without changing CFG beyond the reset value.

Verification
REQ-026 Scenario reset default: the bench SHALL assert RST for 2 cycles -> CFG=37'h15_0008_B038, DONE=0, ERR=0, BUSY=0.
REQ-027 Scenario good frame: the bench SHALL drive header 11110010, 37 ones, parity 1 with DVALID=1 -> BUSY high for 38 cycles, then CFG=37'h1F_FFFF_FFFF, DONE pulses once, ERR=0.
REQ-028 Scenario bad parity: the bench SHALL drive the same frame with parity 0 after reset -> ERR=1, DONE=0, CFG stays 37'h15_0008_B038; a following good frame SHALL clear ERR.
REQ-029 Scenario gapped input: the bench SHALL drive the good frame with DVALID=0 on every other cycle -> identical final CFG, with DONE 1 cycle after the last valid bit.
REQ-030 Scenario false header: the bench SHALL drive 11100010 then 11110011 -> the FSM stays in SYNC, BUSY=0; then 11110010 -> LOAD entered.
REQ-031 Scenario reset mid-load: the bench SHALL assert RST after 20 data bits -> SYNC, CFG = reset value, no DONE; a subsequent full frame SHALL load correctly.

Source files
------------

// File: rtl/clb_cfg_loader.sv
// rtl/clb_cfg_loader.sv - serial CLB configuration loader with header sync and even-parity commit
module clb_cfg_loader (
    input  logic        K,
    input  logic        RST,
    input  logic        DIN,
    input  logic        DVALID,
    output logic [36:0] CFG,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY
);

    localparam logic [36:0] CFG_RESET = 37'h15_0008_B038;
    localparam logic [7:0]  SYNC_HDR  = 8'b1111_0010;
    localparam logic [5:0]  LAST_BIT  = 6'd36;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_LOAD,
        ST_PARITY
    } state_t;

    state_t      state, state_next;
    logic [7:0]  window, window_next, window_shift;
    logic [5:0]  cnt, cnt_next;
    logic [36:0] staging, staging_next;
    logic [36:0] cfg_next;
    logic        done_next;
    logic        err_next;

    assign window_shift = {window[6:0], DIN};

    always_comb begin
        state_next   = state;
        window_next  = window;
        cnt_next     = cnt;
        staging_next = staging;
        cfg_next     = CFG;
        done_next    = 1'b0;
        err_next     = ERR;
        if (DVALID) begin
            case (state)
                ST_SYNC: begin
                    window_next = window_shift;
                    if (window_shift == SYNC_HDR) begin
                        state_next = ST_LOAD;
                        cnt_next   = 6'd0;
                    end
                end
                ST_LOAD: begin
                    // Header patterns inside the payload are plain data; the window is not updated here.
                    staging_next = {staging[35:0], DIN};
                    if (cnt == LAST_BIT) begin
                        state_next = ST_PARITY;
                    end else begin
                        cnt_next = cnt + 6'd1;
                    end
                end
                ST_PARITY: begin
                    if ((^staging ^ DIN) == 1'b0) begin
                        cfg_next  = staging;
                        done_next = 1'b1;
                        err_next  = 1'b0;
                    end else begin
                        err_next = 1'b1;
                    end
                    state_next  = ST_SYNC;
                    window_next = 8'h00;
                    cnt_next    = 6'd0;
                end
                default: begin
                    state_next = ST_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge K) begin
        if (RST) begin
            state   <= ST_SYNC;
            window  <= 8'h00;
            cnt     <= 6'd0;
            staging <= 37'd0;
            CFG     <= CFG_RESET;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_next;
            window  <= window_next;
            cnt     <= cnt_next;
            staging <= staging_next;
            CFG     <= cfg_next;
            DONE    <= done_next;
            ERR     <= err_next;
            BUSY    <= (state_next != ST_SYNC);
        end
    end

endmodule
